uart_txarb: RTL
===============

// Module: uart_txarb
// PURPOSE
//  Round-robin arbiter that shares one uart transmit path (we/din/txavail) between N
//  byte-stream requesters. Grant held for a whole packet (ends on last or MAXLEN bytes).
//  Sits between producer blocks (debug, console, telemetry) and the uart instance.
// PARAMETERS
//  N        4    number of requesters, >=1
//  DATA_    8    byte width; matches the uart DATA_
//  MAXLEN   16   max bytes per grant; packet force-ended at MAXLEN, >=1
//  TIMEOUT  255  idle cycles before a stalled grant is revoked (only with UART_TXARB_TIMEOUT_EN)
// PORTS
//  clk         in   1          clock, all state on rising edge
//  rst         in   1          asynchronous reset, active-high
//  valid       in   N          requester i has a byte on data[i]
//  data        in   N*DATA_    requester i byte at [i*DATA_ +: DATA_]
//  last        in   N          byte from requester i is its packet's final byte
//  ready       out  N          byte of requester i accepted this cycle when valid[i]&ready[i]
//  grant       out  $clog2(N)  index of current owner, valid while busy (min width 1)
//  busy        out  1          a packet is in progress
//  trunc       out  1          1-cycle pulse: packet force-ended at MAXLEN without last
//  uart_we     out  1          write strobe to uart tx fifo
//  uart_din    out  DATA_      byte to uart tx fifo
//  uart_txavail in  1          uart tx fifo not full
// BEHAVIOUR
//  - Reset (async, any time incl. mid-packet): state IDLE, ptr=0, cnt=0, grant=0, busy=0,
//    trunc=0; ready/uart_we combinationally 0. Partial packet abandoned; bytes already in uart stay.
//  - States: IDLE, SEND.
//  - IDLE: if |valid, grant <= first i with valid[i] searching ptr, ptr+1 .. N-1, 0 .. ptr-1;
//    busy<=1, cnt<=0, -> SEND. 1 cycle arbitration latency; no transfer in IDLE.
//  - SEND: ready[i] = (i==grant) & uart_txavail; all other ready bits 0.
//    uart_we = valid[grant] & ready[grant]; uart_din = data[grant] (combinational, no extra latency).
//  - On transfer: cnt++. If last[grant] or cnt==MAXLEN-1: -> IDLE, busy<=0,
//    ptr <= (grant==N-1) ? 0 : grant+1; trunc pulses 1 cycle iff ended by count with last=0.
//  - uart_txavail=0: ready=0, uart_we=0, cnt/state hold (stall, nothing dropped).
//  - Granted requester valid=0: grant held (no preemption); other requesters wait.
//  - Simultaneous requests: only the round-robin winner is granted; losers keep valid high.
//  - Back-to-back: packet end and next grant separated by exactly 1 IDLE cycle.
//  - cnt width $clog2(MAXLEN+1); MAXLEN=1 makes every byte a packet.
//  - N=1: grant always 0, ptr stays 0.
// CONFIGURATION
//  UART_TXARB_TIMEOUT_EN defined: idle counter in SEND counts cycles with valid[grant]=0
//    (cleared on any transfer or when valid[grant]=1); on reaching TIMEOUT -> IDLE, busy<=0,
//    ptr advances as on packet end, output timeout (1 bit, out) pulses 1 cycle. Stalls from
//    uart_txavail=0 with valid=1 do not count. Reset value of timeout: 0.
//  Not defined: no timeout port, no counter; grant held indefinitely until last/MAXLEN.
// TESTING
//  1 single: req1 sends 0xA1,0xA2(last) -> uart_we 2 cycles, din 0xA1,0xA2, grant=1, busy drops after.
//  2 round-robin: valid=4'b1111, 1-byte packets -> grant order 0,1,2,3,0; 1 IDLE cycle between.
//  3 backpressure: uart_txavail=0 for 5 cycles mid-packet -> ready=0, uart_we=0, no byte lost/duplicated.
//  4 truncation: req2 sends 20 bytes with last=0, MAXLEN=16 -> trunc pulse after byte 16, grant
//    moves to req3 if pending, else req2 regrants for remaining 4 bytes.
//  5 reset mid-packet: rst high after byte 3 -> busy=0, ready=0, uart_we=0 same cycle; next grant from req0.
//  6 timeout (macro on, TIMEOUT=8): req0 granted, valid low 8 cycles -> timeout pulse, req1 granted next.

Source files
------------

// File: rtl/uart_txarb.sv
// Round-robin arbiter sharing one uart tx path between N byte-stream requesters; grant held per packet.
// Optional stalled-grant revocation is built when UART_TXARB_TIMEOUT_EN is defined.
module uart_txarb #(
  parameter int N       = 4,
  parameter int DATA_   = 8,
  parameter int MAXLEN  = 16,
  parameter int TIMEOUT = 255,
  localparam int GW     = (N > 1) ? $clog2(N) : 1,
  localparam int CW     = $clog2(MAXLEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       valid,
  input  logic [N*DATA_-1:0] data,
  input  logic [N-1:0]       last,
  output logic [N-1:0]       ready,
  output logic [GW-1:0]      grant,
  output logic               busy,
  output logic               trunc,
  output logic               uart_we,
  output logic [DATA_-1:0]   uart_din,
  input  logic               uart_txavail
`ifdef UART_TXARB_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state, state_nx;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  pick;
  logic [GW-1:0]  idx;
  logic [GW:0]    j;
  logic           found;
  logic [CW-1:0]  cnt;
  logic           xfer;
  logic           at_max;
  logic           pkt_end;
  logic           end_cnt;
  logic           idle_hit;
  logic           rel;
  logic [GW-1:0]  ptr_nx;

  // Rotating priority search starting at ptr, wrapping past N-1 back to 0.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    j     = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr} + (GW+1)'(k);
      if (j >= (GW+1)'(N)) j = j - (GW+1)'(N);
      idx = j[GW-1:0];
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    ready    = '0;
    uart_din = data[int'(grant)*DATA_ +: DATA_];
    if (state == SEND && uart_txavail) ready[grant] = 1'b1;
    xfer    = valid[grant] & ready[grant];
    uart_we = xfer;
    at_max  = (cnt == CW'(MAXLEN - 1));
    pkt_end = xfer & (last[grant] | at_max);
    end_cnt = xfer & at_max & ~last[grant];
    rel     = pkt_end | idle_hit;
    ptr_nx  = (grant == GW'(N - 1)) ? '0 : grant + 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = SEND;
      SEND:    if (rel)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      trunc <= 1'b0;
    end else begin
      trunc <= end_cnt;
      if (state == IDLE) begin
        if (found) begin
          grant <= pick;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      end else if (rel) begin
        busy <= 1'b0;
        ptr  <= ptr_nx;
        cnt  <= '0;
      end else if (xfer) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef UART_TXARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  // Only an absent requester counts toward revocation; uart backpressure never does.
  assign idle_hit = (state == SEND) && !valid[grant] && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= idle_hit;
      if (state != SEND || valid[grant] || idle_hit) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

endmodule
